// File: rtl/mux2_sel.sv
// 2:1 word multiplexer with a combinational output and an optional registered
// capture copy (out_q/valid_q) for debug and retiming taps.
module mux2_sel #(
  parameter int unsigned      WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic             sel,
  input  logic             en,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_q,
  output logic             valid_q
);

  logic [WIDTH-1:0] w_sel_data;
  logic [WIDTH-1:0] r_out_q;
  logic             r_valid_q;

  // Combinational path is kept free of clk/rst_n/en so it is valid during reset.
  always_comb begin
    w_sel_data = in0;
    if (sel) begin
      w_sel_data = in1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_q   <= RESET_VAL;
      r_valid_q <= 1'b0;
    end else if (en) begin
      r_out_q   <= w_sel_data;
      r_valid_q <= 1'b1;
    end
  end

  assign out     = w_sel_data;
  assign out_q   = r_out_q;
  assign valid_q = r_valid_q;

endmodule

// File: tb/tb_mux2_sel.sv
// Self-checking bench for mux2_sel: directed scenarios plus randomized traffic
// checked against a behavioural model of the selection and capture stage.
module tb_mux2_sel;

  localparam int unsigned      WIDTH     = 32;
  localparam logic [WIDTH-1:0] RESET_VAL = 32'h0000_0000;

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] in0;
  logic [WIDTH-1:0] in1;
  logic             sel;
  logic             en;
  logic [WIDTH-1:0] out;
  logic [WIDTH-1:0] out_q;
  logic             valid_q;

  int checks;
  int errors;

  // Reference model state for the capture stage
  logic [WIDTH-1:0] m_q;
  logic             m_valid;

  mux2_sel #(
    .WIDTH    (WIDTH),
    .RESET_VAL(RESET_VAL)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .in0    (in0),
    .in1    (in1),
    .sel    (sel),
    .en     (en),
    .out    (out),
    .out_q  (out_q),
    .valid_q(valid_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Selection expressed as a lookup into the pair of candidate words.
  function automatic logic [WIDTH-1:0] pick(input logic [WIDTH-1:0] a,
                                            input logic [WIDTH-1:0] b,
                                            input logic s);
    logic [WIDTH-1:0] pair [2];
    pair[0] = a;
    pair[1] = b;
    return pair[int'(s)];
  endfunction

  task automatic test_comb();
    in0 = 32'hAAAA_AAAA; in1 = 32'h5555_5555; sel = 1'b0; #1;
    checks++;
    if (out !== 32'hAAAA_AAAA) begin
      errors++; $display("FAIL comb_aa_sel0 got=%h exp=%h", out, 32'hAAAA_AAAA);
    end
    sel = 1'b1; #1;
    checks++;
    if (out !== 32'h5555_5555) begin
      errors++; $display("FAIL comb_55_sel1 got=%h exp=%h", out, 32'h5555_5555);
    end
    in0 = 32'h1234_5678; in1 = 32'hDEAD_BEEF; sel = 1'b0; #1;
    checks++;
    if (out !== 32'h1234_5678) begin
      errors++; $display("FAIL comb_1234_sel0 got=%h exp=%h", out, 32'h1234_5678);
    end
    sel = 1'b1; #1;
    checks++;
    if (out !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL comb_dead_sel1 got=%h exp=%h", out, 32'hDEAD_BEEF);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (out_q !== RESET_VAL) begin
      errors++; $display("FAIL reset_out_q got=%h exp=%h", out_q, RESET_VAL);
    end
    checks++;
    if (valid_q !== 1'b0) begin
      errors++; $display("FAIL reset_valid got=%b exp=0", valid_q);
    end
    sel = 1'b1; in1 = 32'hDEAD_BEEF; #1;
    checks++;
    if (out !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL reset_out_tracks got=%h exp=%h", out, 32'hDEAD_BEEF);
    end
    m_q = RESET_VAL; m_valid = 1'b0;
  endtask

  task automatic test_capture();
    @(negedge clk);
    rst_n = 1'b1; en = 1'b1; sel = 1'b0; in0 = 32'h1234_5678;
    @(posedge clk);
    m_q = 32'h1234_5678; m_valid = 1'b1;
    #1;
    checks++;
    if (out_q !== m_q) begin
      errors++; $display("FAIL capture_out_q got=%h exp=%h", out_q, m_q);
    end
    checks++;
    if (valid_q !== 1'b1) begin
      errors++; $display("FAIL capture_valid got=%b exp=1", valid_q);
    end
  endtask

  task automatic test_hold();
    @(negedge clk);
    en = 1'b0; sel = 1'b1; in0 = 32'h0F0F_0F0F; in1 = 32'hCAFE_F00D;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (out_q !== 32'h1234_5678) begin
      errors++; $display("FAIL hold_out_q got=%h exp=%h", out_q, 32'h1234_5678);
    end
    checks++;
    if (valid_q !== 1'b1) begin
      errors++; $display("FAIL hold_valid got=%b exp=1", valid_q);
    end
    checks++;
    if (out !== 32'hCAFE_F00D) begin
      errors++; $display("FAIL hold_out_tracks got=%h exp=%h", out, 32'hCAFE_F00D);
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    m_q = RESET_VAL; m_valid = 1'b0;
    checks++;
    if (out_q !== RESET_VAL) begin
      errors++; $display("FAIL async_reset_out_q got=%h exp=%h", out_q, RESET_VAL);
    end
    checks++;
    if (valid_q !== 1'b0) begin
      errors++; $display("FAIL async_reset_valid got=%b exp=0", valid_q);
    end
    checks++;
    if (out !== pick(in0, in1, sel)) begin
      errors++; $display("FAIL async_reset_out got=%h exp=%h", out, pick(in0, in1, sel));
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    logic [WIDTH-1:0] exp_out;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      rst_n = 1'b1;
      in0 = $urandom(); in1 = $urandom(); sel = 1'($urandom());
      en  = ($urandom_range(0, 3) != 0);
      #1;
      exp_out = pick(in0, in1, sel);
      checks++;
      if (out !== exp_out) begin
        errors++; $display("FAIL rand_out i=%0d got=%h exp=%h", i, out, exp_out);
      end
      @(posedge clk);
      if (en) begin
        m_q = exp_out; m_valid = 1'b1;
      end
      #1;
      checks++;
      if (out_q !== m_q || valid_q !== m_valid) begin
        errors++;
        $display("FAIL rand_capture i=%0d got=%h/%b exp=%h/%b", i, out_q, valid_q, m_q, m_valid);
      end
      if ($urandom_range(0, 15) == 0) begin
        #1 rst_n = 1'b0;
        #1;
        m_q = RESET_VAL; m_valid = 1'b0;
        checks++;
        if (out_q !== m_q || valid_q !== m_valid) begin
          errors++;
          $display("FAIL rand_reset i=%0d got=%h/%b exp=%h/%b", i, out_q, valid_q, m_q, m_valid);
        end
      end
    end
  endtask

  initial begin
    checks = 0; errors = 0;
    rst_n = 1'b0; en = 1'b0; sel = 1'b0; in0 = '0; in1 = '0;
    m_q = RESET_VAL; m_valid = 1'b0;
    test_comb();
    test_reset();
    test_capture();
    test_hold();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
